// File: rtl/sparc_exu_rslt_byp.sv
// EXU result bypass: stages ALU/load results through M/W/W2, forwards operands
// into E (rs2 inverted), drives the register-file write port and load-use stall.
module sparc_exu_rslt_byp #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          rclk,
  input  logic          reset,
  input  logic [AW-1:0] ifu_exu_rs1_d,
  input  logic [AW-1:0] ifu_exu_rs2_d,
  input  logic [AW-1:0] ifu_exu_rs3_d,
  input  logic          ifu_exu_use_imm_d,
  input  logic [DW-1:0] ifu_exu_imm_data_d,
  input  logic          ifu_exu_vld_d,
  input  logic          ifu_exu_ld_d,
  input  logic [AW-1:0] ifu_exu_rd_d,
  input  logic [DW-1:0] irf_byp_rs1_data_e,
  input  logic [DW-1:0] irf_byp_rs2_data_e,
  input  logic [DW-1:0] irf_byp_rs3_data_e,
  input  logic [DW-1:0] alu_byp_rd_data_e,
  input  logic          ecl_byp_kill_e,
  input  logic          lsu_exu_dfill_vld_w,
  input  logic [DW-1:0] lsu_exu_dfill_data_w,
  output logic [DW-1:0] byp_alu_rs1_data_e,
  output logic [DW-1:0] byp_alu_rs2_data_e_l,
  output logic [DW-1:0] byp_alu_rs3_data_e,
  output logic          byp_irf_wen_w2,
  output logic [AW-1:0] byp_irf_rd_w2,
  output logic [DW-1:0] byp_irf_rd_data_w2,
  output logic          exu_ifu_stall_d
);

  logic [AW-1:0] rs1_e_q, rs2_e_q, rs3_e_q, rd_e_q;
  logic          use_imm_e_q, ld_e_q, valid_e_q;
  logic [DW-1:0] imm_e_q;

  logic          valid_m_q, ld_m_q, valid_w_q, ld_w_q, valid_w2_q;
  logic [AW-1:0] rd_m_q, rd_w_q, rd_w2_q;
  logic [DW-1:0] data_m_q, data_w_q, data_w2_q;

  logic          stall_d;
  logic          valid_m_d, valid_w2_d;
  logic          w_fwd_ok;
  logic [DW-1:0] data_w_eff;
  logic [DW-1:0] rs1_fwd, rs2_fwd, rs3_fwd;
  logic          hit_rs1_d, hit_rs2_d, hit_rs3_d;

  // A load sitting in W only has usable data in the cycle the fill arrives.
  assign data_w_eff = ld_w_q ? lsu_exu_dfill_data_w : data_w_q;
  assign w_fwd_ok   = valid_w_q & (~ld_w_q | lsu_exu_dfill_vld_w);
  assign valid_m_d  = valid_e_q & ~ecl_byp_kill_e;
  assign valid_w2_d = valid_w_q & (~ld_w_q | lsu_exu_dfill_vld_w);

  assign hit_rs1_d = (rd_e_q == ifu_exu_rs1_d);
  assign hit_rs2_d = (rd_e_q == ifu_exu_rs2_d) & ~ifu_exu_use_imm_d;
  assign hit_rs3_d = (rd_e_q == ifu_exu_rs3_d);
  assign stall_d   = ifu_exu_vld_d & valid_e_q & ld_e_q & ~ecl_byp_kill_e &
                     (rd_e_q != '0) & (hit_rs1_d | hit_rs2_d | hit_rs3_d);

  // Youngest matching stage wins; loads in M have no data yet and are skipped.
  function automatic logic [DW-1:0] fwd_src(input logic [AW-1:0] rs,
                                            input logic [DW-1:0] rf_data);
    logic [DW-1:0] r;
    r = rf_data;
    if (rs != '0) begin
      if (valid_m_q & ~ld_m_q & (rd_m_q == rs))   r = data_m_q;
      else if (w_fwd_ok & (rd_w_q == rs))         r = data_w_eff;
      else if (valid_w2_q & (rd_w2_q == rs))      r = data_w2_q;
    end
    return r;
  endfunction

  always_comb begin
    rs1_fwd = fwd_src(rs1_e_q, irf_byp_rs1_data_e);
    rs2_fwd = fwd_src(rs2_e_q, irf_byp_rs2_data_e);
    rs3_fwd = fwd_src(rs3_e_q, irf_byp_rs3_data_e);
  end

  assign byp_alu_rs1_data_e   = rs1_fwd;
  assign byp_alu_rs2_data_e_l = ~(use_imm_e_q ? imm_e_q : rs2_fwd);
  assign byp_alu_rs3_data_e   = rs3_fwd;
  assign byp_irf_wen_w2       = valid_w2_q & (rd_w2_q != '0);
  assign byp_irf_rd_w2        = rd_w2_q;
  assign byp_irf_rd_data_w2   = data_w2_q;
  assign exu_ifu_stall_d      = stall_d;

  always_ff @(posedge rclk) begin
    if (reset) begin
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rs3_e_q     <= '0;
      rd_e_q      <= '0;
      use_imm_e_q <= 1'b0;
      imm_e_q     <= '0;
      ld_e_q      <= 1'b0;
      valid_e_q   <= 1'b0;
      valid_m_q   <= 1'b0;
      ld_m_q      <= 1'b0;
      rd_m_q      <= '0;
      data_m_q    <= '0;
      valid_w_q   <= 1'b0;
      ld_w_q      <= 1'b0;
      rd_w_q      <= '0;
      data_w_q    <= '0;
      valid_w2_q  <= 1'b0;
      rd_w2_q     <= '0;
      data_w2_q   <= '0;
    end else begin
      // On a stall E becomes a bubble; the IFU holds D so fields can stay put.
      if (stall_d) begin
        valid_e_q <= 1'b0;
      end else begin
        rs1_e_q     <= ifu_exu_rs1_d;
        rs2_e_q     <= ifu_exu_rs2_d;
        rs3_e_q     <= ifu_exu_rs3_d;
        rd_e_q      <= ifu_exu_rd_d;
        use_imm_e_q <= ifu_exu_use_imm_d;
        imm_e_q     <= ifu_exu_imm_data_d;
        ld_e_q      <= ifu_exu_ld_d;
        valid_e_q   <= ifu_exu_vld_d;
      end
      valid_m_q  <= valid_m_d;
      ld_m_q     <= ld_e_q;
      rd_m_q     <= rd_e_q;
      data_m_q   <= alu_byp_rd_data_e;
      valid_w_q  <= valid_m_q;
      ld_w_q     <= ld_m_q;
      rd_w_q     <= rd_m_q;
      data_w_q   <= data_m_q;
      valid_w2_q <= valid_w2_d;
      rd_w2_q    <= rd_w_q;
      data_w2_q  <= data_w_eff;
    end
  end

  a_fill_with_load: assert property (@(posedge rclk) disable iff (reset)
    (valid_w_q & ld_w_q) |-> lsu_exu_dfill_vld_w);

endmodule

// File: tb/tb_sparc_exu_rslt_byp.sv
// Directed bench for sparc_exu_rslt_byp: per-cycle vector table covering
// forwarding, write-back, load-use stall and kill, plus a reset-mid-flight sequence.
module tb_sparc_exu_rslt_byp;

  localparam logic [63:0] R1 = 64'h11;
  localparam logic [63:0] R2 = 64'h22;
  localparam logic [63:0] R3 = 64'h33;
  localparam logic [63:0] FL = 64'hDEADBEEF;
  localparam logic [63:0] Z  = 64'h0;

  logic        rclk;
  logic        reset;
  logic [4:0]  rs1_d, rs2_d, rs3_d, rd_d;
  logic        use_imm_d, vld_d, ld_d;
  logic [63:0] imm_d;
  logic [63:0] irf1, irf2, irf3, alu_data;
  logic        kill_e;
  logic        dfill_vld;
  logic [63:0] dfill_data;
  logic [63:0] rs1_o, rs2_l_o, rs3_o;
  logic        wen_o;
  logic [4:0]  rd_w2_o;
  logic [63:0] wdata_o;
  logic        stall_o;

  sparc_exu_rslt_byp dut (
    .rclk                 (rclk),
    .reset                (reset),
    .ifu_exu_rs1_d        (rs1_d),
    .ifu_exu_rs2_d        (rs2_d),
    .ifu_exu_rs3_d        (rs3_d),
    .ifu_exu_use_imm_d    (use_imm_d),
    .ifu_exu_imm_data_d   (imm_d),
    .ifu_exu_vld_d        (vld_d),
    .ifu_exu_ld_d         (ld_d),
    .ifu_exu_rd_d         (rd_d),
    .irf_byp_rs1_data_e   (irf1),
    .irf_byp_rs2_data_e   (irf2),
    .irf_byp_rs3_data_e   (irf3),
    .alu_byp_rd_data_e    (alu_data),
    .ecl_byp_kill_e       (kill_e),
    .lsu_exu_dfill_vld_w  (dfill_vld),
    .lsu_exu_dfill_data_w (dfill_data),
    .byp_alu_rs1_data_e   (rs1_o),
    .byp_alu_rs2_data_e_l (rs2_l_o),
    .byp_alu_rs3_data_e   (rs3_o),
    .byp_irf_wen_w2       (wen_o),
    .byp_irf_rd_w2        (rd_w2_o),
    .byp_irf_rd_data_w2   (wdata_o),
    .exu_ifu_stall_d      (stall_o)
  );

  // Clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic        vld, ld, use_imm, kill;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic [63:0] imm, alu;
    logic [63:0] e_rs1, e_rs2, e_rs3;
    logic        e_stall, e_wen;
    logic [4:0]  e_rd;
    logic [63:0] e_wd;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur   = 0;

  function automatic vec_t mk(input int vld, ld, ui, kl, rs1, rs2, rs3, rd,
                              input logic [63:0] imm, alu, e1, e2, e3,
                              input int stall, wen, wrd,
                              input logic [63:0] wd);
    vec_t v;
    v.vld = vld[0];  v.ld = ld[0];  v.use_imm = ui[0];  v.kill = kl[0];
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rs3 = 5'(rs3); v.rd = 5'(rd);
    v.imm = imm;     v.alu = alu;
    v.e_rs1 = e1;    v.e_rs2 = e2;    v.e_rs3 = e3;
    v.e_stall = stall[0]; v.e_wen = wen[0]; v.e_rd = 5'(wrd); v.e_wd = wd;
    return v;
  endfunction

  // Scoreboard check
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
    end
  endtask

  // Driver
  task automatic drive_d(input vec_t v);
    vld_d = v.vld; ld_d = v.ld; use_imm_d = v.use_imm; kill_e = v.kill;
    rs1_d = v.rs1; rs2_d = v.rs2; rs3_d = v.rs3; rd_d = v.rd;
    imm_d = v.imm; alu_data = v.alu;
  endtask

  task automatic nop_d();
    drive_d(mk(0,0,0,0, 0,0,0,0, Z, Z, Z, Z, Z, 0, 0,0, Z));
  endtask

  initial begin
    // Rows: D inputs | E-stage alu/kill | expected rs1,rs2(uninverted),rs3 | stall | wen,rd,data
    tv.push_back(mk(1,0,0,0,  3, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,0,  1, 2, 0, 5, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,0,  5, 5, 0, 0, Z, 64'h1234,     R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,0,  0, 0, 0, 7, Z, 64'h55,       64'h1234, 64'h1234, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,0,  1, 2, 3,10, Z, 64'h7777,     R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,0,  1, 2, 3,11, Z, 64'hAAAA,     R1, R2, R3, 0, 1, 5, 64'h1234));
    tv.push_back(mk(1,0,0,0,  7, 7, 5, 0, Z, 64'hBBBB,     R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,1,0,0,  0, 0, 0, 9, Z, Z,            64'h7777, 64'h7777, R3, 0, 1, 7, 64'h7777));
    tv.push_back(mk(1,0,0,0,  9, 0, 0, 0, Z, Z,            R1, R2, R3, 1, 1,10, 64'hAAAA));
    tv.push_back(mk(1,0,0,0,  9, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 1,11, 64'hBBBB));
    tv.push_back(mk(1,0,0,0,  0, 0, 0, 0, Z, Z,            FL, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,1,0,  0, 0, 0, 0, 64'h5A, 64'hFF,  R1, R2, R3, 0, 1, 9, FL));
    tv.push_back(mk(1,0,0,0,  0, 0, 0, 4, Z, Z,            R1, 64'h5A, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,1,  4, 4, 4, 0, Z, 64'h4444,     R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(0,0,0,0,  0, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(0,0,0,0,  0, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(0,0,0,0,  0, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,1,0,0,  0, 0, 0,12, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,1, 12, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(0,0,0,0,  0, 0, 0, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,1,0,0,  0, 0, 0,13, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,1,0,  0,13, 0, 0, 64'h77, Z,       R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(0,0,0,0,  0, 0, 0, 0, Z, Z,            R1, 64'h77, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,1,0,0,  0, 0, 0,14, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(1,0,0,0,  0, 0,14, 0, Z, Z,            R1, R2, R3, 1, 1,13, FL));
    tv.push_back(mk(1,0,0,0,  0, 0,14, 0, Z, Z,            R1, R2, R3, 0, 0, 0, Z));
    tv.push_back(mk(0,0,0,0,  0, 0, 0, 0, Z, Z,            R1, R2, FL, 0, 0, 0, Z));

    irf1 = R1; irf2 = R2; irf3 = R3;
    dfill_vld = 1'b1; dfill_data = FL;
    nop_d();
    reset = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    reset = 1'b0;
    #1;
    cur = -1;
    chk("reset_wen",   64'(wen_o),   Z);
    chk("reset_stall", 64'(stall_o), Z);
    chk("reset_rd_w2", 64'(rd_w2_o), Z);
    chk("reset_wdata", wdata_o,      Z);
    chk("reset_rs1",   rs1_o,        R1);
    chk("reset_rs2_l", rs2_l_o,      ~R2);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge rclk);
      cur = i;
      drive_d(tv[i]);
      #1;
      chk("rs1",   rs1_o,            tv[i].e_rs1);
      chk("rs2_l", rs2_l_o,          ~tv[i].e_rs2);
      chk("rs3",   rs3_o,            tv[i].e_rs3);
      chk("stall", 64'(stall_o),     64'(tv[i].e_stall));
      chk("wen",   64'(wen_o),       64'(tv[i].e_wen));
      if (tv[i].e_wen) begin
        chk("wb_rd",   64'(rd_w2_o), 64'(tv[i].e_rd));
        chk("wb_data", wdata_o,      tv[i].e_wd);
      end
    end

    // Reset while a writer is in flight and a load-use stall is pending.
    cur = 100;
    repeat (3) begin @(negedge rclk); nop_d(); end
    @(negedge rclk);
    drive_d(mk(1,0,0,0, 0,0,0,6, Z, Z, Z, Z, Z, 0, 0,0, Z));
    @(negedge rclk);
    drive_d(mk(1,1,0,0, 0,0,0,8, Z, 64'h6666, Z, Z, Z, 0, 0,0, Z));
    @(negedge rclk);
    cur = 101;
    drive_d(mk(1,0,0,0, 8,0,0,0, Z, Z, Z, Z, Z, 0, 0,0, Z));
    #1;
    chk("pre_reset_stall", 64'(stall_o), 64'h1);
    reset = 1'b1;
    @(negedge rclk);
    cur = 102;
    reset = 1'b0;
    #1;
    chk("post_reset_stall", 64'(stall_o), Z);
    chk("post_reset_wen",   64'(wen_o),   Z);
    chk("post_reset_rd",    64'(rd_w2_o), Z);
    chk("post_reset_wdata", wdata_o,      Z);
    @(negedge rclk);
    cur = 103;
    nop_d();
    #1;
    chk("flushed_wen", 64'(wen_o), Z);
    chk("flushed_rs1", rs1_o,      R1);
    @(negedge rclk);
    cur = 104;
    #1;
    chk("flushed_wen2", 64'(wen_o), Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
